// File: rtl/regblock_seq_pkg.sv
// Shared types for the regblock command sequencer: FSM state encoding and
// the command record carried through the in-order command FIFO.
package regblock_seq_pkg;

    // Widest data path the command record can carry; instances use WIDTH <= this.
    localparam int SEQ_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic                  write;
        logic                  index;
        logic [SEQ_DATA_W-1:0] data;
    } seq_cmd_t;

endpackage

// File: rtl/regblock_cmd_fifo.sv
// In-order DEPTH-entry command FIFO. The caller gates push/pop, so the
// occupancy counter can never over- or underflow.
module regblock_cmd_fifo
    import regblock_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  seq_cmd_t         din,
    output seq_cmd_t         dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    seq_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy are control state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regblock_cmd_sequencer.sv
// Command sequencer in front of one regblock copy: queues read/write commands
// and replays them in program order, returning read data on a response channel.
module regblock_cmd_sequencer
    import regblock_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic                         cmd_index,
    input  logic [WIDTH-1:0]             cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_index,
    output logic [WIDTH-1:0]             rsp_data,
    output logic                         rb_en,
    output logic                         rb_wr_index,
    output logic                         rb_rd_index,
    output logic [WIDTH-1:0]             rb_d,
    input  logic [WIDTH-1:0]             rb_q,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    seq_state_e state;
    seq_cmd_t   push_cmd;
    seq_cmd_t   head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    // No bypass: a full FIFO refuses even when the FSM pops the same cycle.
    assign cmd_ready = !fifo_full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !fifo_empty;

    always_comb begin
        push_cmd       = '0;
        push_cmd.write = cmd_write;
        push_cmd.index = cmd_index;
        push_cmd.data  = SEQ_DATA_W'(cmd_data);
    end

    regblock_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_cmd),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // The read index stays on rb_rd_index through CAPTURE, so it doubles as rsp_index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rb_en       <= 1'b0;
            rb_wr_index <= 1'b0;
            rb_rd_index <= 1'b0;
            rb_d        <= '0;
            rsp_valid   <= 1'b0;
            rsp_index   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head.write) begin
                            state       <= WRITE;
                            rb_en       <= 1'b1;
                            rb_wr_index <= head.index;
                            rb_d        <= head.data[WIDTH-1:0];
                        end else begin
                            state       <= READ;
                            rb_rd_index <= head.index;
                        end
                    end
                end
                WRITE: begin
                    rb_en <= 1'b0;
                    state <= IDLE;
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data  <= rb_q;
                    rsp_index <= rb_rd_index;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rb_en     <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regblock_cmd_sequencer.sv
// Directed bench for regblock_cmd_sequencer with a two-register regblock model
// behind the rb_* pins.
module tb_regblock_cmd_sequencer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic                       cmd_index;
    logic [WIDTH-1:0]           cmd_data;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_index;
    logic [WIDTH-1:0]           rsp_data;
    logic                       rb_en;
    logic                       rb_wr_index;
    logic                       rb_rd_index;
    logic [WIDTH-1:0]           rb_d;
    logic [WIDTH-1:0]           rb_q;
    logic [$clog2(DEPTH+1)-1:0] level;

    regblock_cmd_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_index   (cmd_index),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_index   (rsp_index),
        .rsp_data    (rsp_data),
        .rb_en       (rb_en),
        .rb_wr_index (rb_wr_index),
        .rb_rd_index (rb_rd_index),
        .rb_d        (rb_d),
        .rb_q        (rb_q),
        .level       (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register block model: write on rb_en at the edge, combinational read.
    logic [WIDTH-1:0] regs [2] = '{32'h0, 32'h0};
    always @(posedge clk) begin
        if (rb_en) regs[rb_wr_index] <= rb_d;
    end
    assign rb_q = regs[rb_rd_index];

    int               en_count = 0;
    int               en_cyc_q[$];
    logic [WIDTH-1:0] rbd_q[$];
    int               max_level = 0;
    always @(negedge clk) begin
        if (rb_en) begin
            en_count <= en_count + 1;
            en_cyc_q.push_back(cyc);
            rbd_q.push_back(rb_d);
        end
        if (int'(level) > max_level) max_level <= int'(level);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic idx, input logic [WIDTH-1:0] d, output int acc_cyc);
        int guard;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_index = idx;
        cmd_data  = d;
        while (!cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("send_timeout", 64'(guard), 64'(0));
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int at);
        int guard;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("rsp_timeout", 64'(guard), 64'(0));
        at = cyc;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int a, b, t, base, snap, got;
        logic [WIDTH-1:0] held;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_index = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        // Reset held three cycles
        repeat (3) tick();
        check("rst_rb_en",     64'(rb_en),       64'(0));
        check("rst_rb_wr_idx", 64'(rb_wr_index), 64'(0));
        check("rst_rb_rd_idx", 64'(rb_rd_index), 64'(0));
        check("rst_rb_d",      64'(rb_d),        64'(0));
        check("rst_rsp_valid", 64'(rsp_valid),   64'(0));
        check("rst_rsp_index", 64'(rsp_index),   64'(0));
        check("rst_rsp_data",  64'(rsp_data),    64'(0));
        check("rst_level",     64'(level),       64'(0));
        check("rst_cmd_ready", 64'(cmd_ready),   64'(0));
        rst = 1'b0;
        tick();
        check("post_rst_ready", 64'(cmd_ready), 64'(1));
        check("post_rst_level", 64'(level),     64'(0));

        // Write idx1 then read idx1 on the next cycle
        base = en_count;
        send(1'b1, 1'b1, 32'hDEAD_BEEF, a);
        send(1'b0, 1'b1, 32'h0, b);
        check("wr_rd_accept_gap", 64'(b), 64'(a + 1));
        wait_rsp(t);
        check("rd_rsp_cycle", 64'(t),         64'(a + 5));
        check("rd_rsp_index", 64'(rsp_index), 64'(1));
        check("rd_rsp_data",  64'(rsp_data),  64'(32'hDEAD_BEEF));
        check("wr_en_pulses", 64'(en_count - base), 64'(1));
        check("wr_en_cycle",  64'(en_cyc_q[base]),  64'(a + 1));
        ack();
        check("rsp_drop", 64'(rsp_valid), 64'(0));
        repeat (3) tick();
        check("rd_no_en", 64'(en_count - base), 64'(1));

        // Fill: one write then five reads with rsp_ready low
        send(1'b1, 1'b0, 32'h1234_5678, a);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 32'h0, b);
        check("fill_level",     64'(level),     64'(DEPTH));
        check("fill_cmd_ready", 64'(cmd_ready), 64'(0));
        check("fill_rsp_valid", 64'(rsp_valid), 64'(1));
        check("fill_rsp_data",  64'(rsp_data),  64'(32'h1234_5678));
        held = rsp_data;

        // Backpressure: extra command offered, response not taken for 10 cycles
        snap      = en_count;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_index = 1'b1;
        cmd_data  = 32'h55;
        repeat (10) tick();
        check("bp_level",     64'(level),     64'(DEPTH));
        check("bp_rsp_data",  64'(rsp_data),  64'(held));
        check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
        check("bp_no_en",     64'(en_count - snap), 64'(0));
        cmd_valid = 1'b0;
        ack();
        check("bp_rsp_drop", 64'(rsp_valid), 64'(0));
        tick();
        check("bp_next_pop", 64'(level), 64'(DEPTH - 1));

        got       = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid) begin
                got++;
                check("drain_data",  64'(rsp_data),  64'(32'h1234_5678));
                check("drain_index", 64'(rsp_index), 64'(0));
            end
        end
        rsp_ready = 1'b0;
        check("drain_count", 64'(got),   64'(4));
        check("drain_level", 64'(level), 64'(0));

        // Wrap: twelve writes alternating idx0/idx1, data 1..12
        base = en_count;
        for (int i = 1; i <= 3 * DEPTH; i++) send(1'b1, logic'(i % 2 == 0), WIDTH'(i), a);
        repeat (12) tick();
        check("wrap_pulses", 64'(en_count - base), 64'(3 * DEPTH));
        for (int i = 0; i < 3 * DEPTH; i++) check("wrap_rb_d", 64'(rbd_q[base + i]), 64'(i + 1));
        for (int i = 1; i < 3 * DEPTH; i++)
            check("wrap_gap", 64'(en_cyc_q[base + i] - en_cyc_q[base + i - 1]), 64'(2));
        check("wrap_max_level", 64'(max_level <= DEPTH), 64'(1));
        send(1'b0, 1'b0, 32'h0, a);
        wait_rsp(t);
        check("wrap_rd0", 64'(rsp_data), 64'(11));
        ack();
        send(1'b0, 1'b1, 32'h0, a);
        wait_rsp(t);
        check("wrap_rd1_data",  64'(rsp_data),  64'(12));
        check("wrap_rd1_index", 64'(rsp_index), 64'(1));
        ack();

        // Async reset while a write is on the pins
        base = en_count;
        send(1'b1, 1'b0, 32'hA, a);
        send(1'b1, 1'b0, 32'hB, b);
        send(1'b1, 1'b0, 32'hC, b);
        got = 0;
        while (!rb_en && got < 20) begin
            tick();
            got++;
        end
        check("arst_write_seen", 64'(rb_en), 64'(1));
        check("arst_first_done", 64'(en_count - base), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_rb_en",     64'(rb_en),     64'(0));
        check("arst_level",     64'(level),     64'(0));
        check("arst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (2) tick();
        rst  = 1'b0;
        snap = en_count;
        repeat (10) tick();
        check("arst_no_replay", 64'(en_count - snap), 64'(0));
        check("arst_level_rel", 64'(level),     64'(0));
        check("arst_ready_rel", 64'(cmd_ready), 64'(1));
        send(1'b0, 1'b0, 32'h0, a);
        wait_rsp(t);
        check("arst_rd0", 64'(rsp_data), 64'(32'hA));
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regblock_cmd_sequencer.md
# regblock_cmd_sequencer

Upstream command stage for `regblock`. It accepts read/write commands on a valid/ready interface and buffers them in a small in-order FIFO. It drives the register block's `en`/`wr_index`/`rd_index`/`d` pins and returns read data on a valid/ready response channel. One instance feeds each `regblock` copy in the equivalence miter, so per-copy command streams can be compared at the transaction level.

## Interface
Parameters:
- `WIDTH`, 32: data width; matches `regblock` `d`/`q`.
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: FIFO can accept (`!full && !rst`).
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_index`  in  1: target register.
- `cmd_data`  in  WIDTH: write data (ignored for reads).
- `rsp_valid`  out  1: read response available.
- `rsp_ready`  in  1: consumer accepts response.
- `rsp_index`  out  1: index of the read being returned.
- `rsp_data`  out  WIDTH: read data.
- `rb_en`  out  1: to `regblock.en`.
- `rb_wr_index`  out  1: to `regblock.wr_index`.
- `rb_rd_index`  out  1: to `regblock.rd_index`.
- `rb_d`  out  WIDTH: to `regblock.d`.
- `rb_q`  in  WIDTH: from `regblock.q`.
- `level`  out  $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- Push on `cmd_valid && cmd_ready`; `{write,index,data}` enqueued. No bypass: when full, `cmd_ready` = 0 even if a pop occurs that cycle.
- Simultaneous push and pop (not full): both happen, `level` unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop head. A write goes to WRITE; a read goes to READ.
  - WRITE: `rb_en` = 1, `rb_wr_index` and `rb_d` from the popped command. Exactly one cycle, then IDLE.
  - READ: `rb_rd_index` = popped index for one cycle, then CAPTURE.
  - CAPTURE: `rsp_data` <= `rb_q`, `rsp_index` <= index; go to RESP.
  - RESP: `rsp_valid` = 1 and held with data stable until `rsp_ready`; then IDLE. No further pops while in RESP.
- Strict program order. A read after a write to the same index returns the new value, because the write completes before the read issues.
- All `rb_*` and `rsp_*` outputs are registered.
- `rb_en` = 0 outside WRITE. `rb_wr_index`, `rb_rd_index` and `rb_d` hold their last value when not in use.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. `level` saturates neither way: overflow and underflow are impossible by construction.

## Timing
- Reset values: `rb_en`, `rb_wr_index`, `rb_rd_index`, `rb_d`, `rsp_valid`, `rsp_index`, `rsp_data`, `level` = 0; `cmd_ready` = 0 while `rst` is high, 1 after release. FSM = IDLE.
- Write: command accepted in cycle N → popped in N+1 → `rb_en` high in cycle N+2 only.
- Read: accepted in N → popped in N+1 → `rb_rd_index` driven in N+2 → `rb_q` sampled at the end of N+3 → `rsp_valid` high from N+4.
- Back-to-back writes: one `rb_en` pulse every 2 cycles.
- Reset mid-operation: asynchronous. FIFO flushed, an in-flight write is dropped (`rb_en` falls immediately), a pending response is discarded.

## Structure
- Package `regblock_seq_pkg`: state enum `seq_state_e` (IDLE, WRITE, READ, CAPTURE, RESP) and struct `seq_cmd_t {write, index, data[WIDTH-1:0]}`.
- Sub-module `regblock_cmd_fifo`: parameterised DEPTH×`seq_cmd_t` FIFO with `full`, `empty`, `level` and async reset.
- Top level contains only the FSM and output registers.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs 0, `cmd_ready` = 0; after release, `cmd_ready` = 1 and `level` = 0.
- Write then read: write idx1 = 0xDEADBEEF at N, read idx1 at N+1 → `rb_en` only in N+2; `rsp_valid` with `rsp_index` = 1, `rsp_data` = 0xDEADBEEF; `rb_en` never asserted for the read.
- Fill: with `rsp_ready` = 0, push 5 reads, DEPTH = 4 → `cmd_ready` drops after 4 accepted (first already popped counts); the response is held stable until `rsp_ready`.
- Backpressure: hold `rsp_ready` low 10 cycles → `rsp_data` unchanged, no pops; raise it → one handshake, then the next command proceeds.
- Wrap: push/pop 3×DEPTH alternating writes to idx0/idx1 with data 1..12 → `rb_d` sequence 1..12 in order, `level` never exceeds DEPTH.
- Async reset during WRITE: assert `rst` mid-cycle → `rb_en` falls before the next edge; after release, queued commands are gone and `level` = 0.
